channel_scan_mux: RTL and testbench

Parametrised, registered channel selector for the multi-channel impulse counter. It synchronises `NUM_CH` asynchronous impulse inputs and routes one of them, chosen by a loadable selection register or by an automatic round-robin scan, to a single counter path. It also emits a one-cycle pulse on each rising edge of the selected channel. It sits between the input pads and the shared impulse counter.

---
 rtl/chan_mux_pkg.sv | 17 +
 rtl/sync_2ff.sv | 26 ++
 rtl/channel_scan_mux.sv | 133 +++++++++++++
 tb/tb_channel_scan_mux.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/chan_mux_pkg.sv
// Shared definitions for the impulse-counter channel selector:
// the "no channel" code, scan FSM encoding and selection-code validity test.
package chan_mux_pkg;

  localparam int unsigned SEL_NONE = 0;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } scan_state_e;

  // True when a code addresses a real channel (1..num_ch).
  function automatic logic code_valid(input int unsigned code, input int unsigned num_ch);
    return (code >= 1) && (code <= num_ch);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for an asynchronous impulse input.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state always uses non-blocking assignments so that every
  // flop samples the pre-edge value; blocking here would collapse both stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/channel_scan_mux.sv
// Registered channel selector: synchronises NUM_CH impulse inputs and routes one,
// chosen by load or round-robin scan, to data_out with a rising-edge pulse.
module channel_scan_mux
  import chan_mux_pkg::*;
#(
  parameter int unsigned NUM_CH  = 9,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [NUM_CH-1:0]  data_in,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic               sel_load,
  input  logic               scan_en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               data_out,
  output logic               pulse_out,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               sel_err
);

  logic [NUM_CH-1:0]  w_sync;
  logic               w_sel_bit;
  logic               w_load_valid;
  logic [DWELL_W-1:0] w_dwell_last;
  logic               w_dwell_done;
  logic [SEL_W-1:0]   w_adv_sel;
  logic [SEL_W-1:0]   w_cur_sel_nxt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic               w_sel_err_nxt;
  scan_state_e        w_state_nxt;

  scan_state_e        r_state;
  logic [SEL_W-1:0]   r_cur_sel;
  logic [SEL_W-1:0]   r_cur_sel_d;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic               r_sel_err;
  logic               r_data_out;
  logic               r_pulse;

  // Synchronisers are free-running; ena only gates the selection logic.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (data_in[g]),
      .o_q   (w_sync[g])
    );
  end

  // Code 0 (and anything out of range) selects a constant 0.
  always_comb begin
    w_sel_bit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_cur_sel == SEL_W'(i + 1)) w_sel_bit = w_sync[i];
    end
  end

  // Code 0 is loadable ("no channel"); only codes above NUM_CH are rejected.
  assign w_load_valid = (sel_in == SEL_W'(SEL_NONE)) || code_valid(32'(sel_in), NUM_CH);
  assign w_dwell_last = (dwell == '0) ? '0 : dwell - 1'b1;
  assign w_dwell_done = (r_dwell_cnt >= w_dwell_last);
  assign w_adv_sel    = ((r_cur_sel == SEL_W'(SEL_NONE)) || (r_cur_sel >= SEL_W'(NUM_CH)))
                        ? SEL_W'(1) : r_cur_sel + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    if (ena) begin
      case (r_state)
        MANUAL:  if (scan_en)  w_state_nxt = SCAN;
        SCAN:    if (!scan_en) w_state_nxt = MANUAL;
        default: w_state_nxt = MANUAL;
      endcase
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_cur_sel_nxt = r_cur_sel;
    w_cnt_nxt     = r_dwell_cnt;
    w_sel_err_nxt = 1'b0;
    if (ena) begin
      // Holding the counter at 0 in MANUAL gives the clear on entry to SCAN.
      if (r_state == MANUAL) begin
        w_cnt_nxt = '0;
      end else if (w_dwell_done) begin
        w_cnt_nxt     = '0;
        w_cur_sel_nxt = w_adv_sel;
      end else begin
        w_cnt_nxt = r_dwell_cnt + 1'b1;
      end
      // A valid load overrides any advance; a rejected one leaves the scan alone.
      if (sel_load) begin
        if (w_load_valid) begin
          w_cur_sel_nxt = sel_in;
          w_cnt_nxt     = '0;
        end else begin
          w_sel_err_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= MANUAL;
      r_cur_sel   <= SEL_W'(SEL_NONE);
      r_cur_sel_d <= SEL_W'(SEL_NONE);
      r_dwell_cnt <= '0;
      r_sel_err   <= 1'b0;
      r_data_out  <= 1'b0;
      r_pulse     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_sel   <= w_cur_sel_nxt;
      r_cur_sel_d <= r_cur_sel;
      r_dwell_cnt <= w_cnt_nxt;
      r_sel_err   <= w_sel_err_nxt;
      if (ena) r_data_out <= w_sel_bit;
      // Comparing against the delayed selection masks the edge a switch would fake.
      r_pulse     <= ena & w_sel_bit & ~r_data_out & (r_cur_sel == r_cur_sel_d);
    end
  end

  assign data_out  = r_data_out;
  assign pulse_out = r_pulse;
  assign cur_sel   = r_cur_sel;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_channel_scan_mux.sv
// Directed bench for channel_scan_mux: vector table for manual mode, then
// hand-written sequences for scan wrap, load priority, enable freeze and reset.
module tb_channel_scan_mux;

  localparam int NUM_CH  = 9;
  localparam int SEL_W   = 4;
  localparam int DWELL_W = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ena;
  logic [NUM_CH-1:0]  data_in;
  logic [SEL_W-1:0]   sel_in;
  logic               sel_load;
  logic               scan_en;
  logic [DWELL_W-1:0] dwell;
  logic               data_out;
  logic               pulse_out;
  logic [SEL_W-1:0]   cur_sel;
  logic               sel_err;

  int n_checks = 0;
  int n_fail   = 0;

  channel_scan_mux #(
    .NUM_CH  (NUM_CH),
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .data_in   (data_in),
    .sel_in    (sel_in),
    .sel_load  (sel_load),
    .scan_en   (scan_en),
    .dwell     (dwell),
    .data_out  (data_out),
    .pulse_out (pulse_out),
    .cur_sel   (cur_sel),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              ena;
    logic              load;
    logic [SEL_W-1:0]  sel;
    logic [NUM_CH-1:0] din;
    logic [SEL_W-1:0]  exp_sel;
    logic              exp_dout;
    logic              exp_pulse;
    logic              exp_err;
  } vec_t;

  vec_t vecs[27];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic l, input int s, input int d,
                              input int xs, input logic xd, input logic xp, input logic xe);
    vec_t v;
    v.ena = e; v.load = l; v.sel = SEL_W'(s); v.din = NUM_CH'(d);
    v.exp_sel = SEL_W'(xs); v.exp_dout = xd; v.exp_pulse = xp; v.exp_err = xe;
    return v;
  endfunction

  function automatic int exp_scan(input int k);
    return (k < 4) ? 0 : ((k - 4) / 4) % NUM_CH + 1;
  endfunction

  task automatic check_all(input string tag, input int xs, input logic xd,
                           input logic xp, input logic xe);
    check({tag, "_sel"},   32'(cur_sel),   32'(xs));
    check({tag, "_dout"},  32'(data_out),  32'(xd));
    check({tag, "_pulse"}, 32'(pulse_out), 32'(xp));
    check({tag, "_err"},   32'(sel_err),   32'(xe));
  endtask

  initial begin
    // Manual-mode table; each row is applied, one edge passes, outputs compared.
    vecs[0]  = mk(1, 1, 3,  'h000, 3, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0,  'h000, 3, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0,  'h004, 3, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0,  'h004, 3, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0,  'h004, 3, 1, 1, 0);
    vecs[5]  = mk(1, 0, 0,  'h004, 3, 1, 0, 0);
    vecs[6]  = mk(1, 0, 0,  'h000, 3, 1, 0, 0);
    vecs[7]  = mk(1, 0, 0,  'h000, 3, 1, 0, 0);
    vecs[8]  = mk(1, 0, 0,  'h000, 3, 0, 0, 0);
    vecs[9]  = mk(1, 1, 5,  'h010, 5, 0, 0, 0);
    vecs[10] = mk(1, 0, 0,  'h010, 5, 0, 0, 0);
    vecs[11] = mk(1, 0, 0,  'h010, 5, 1, 1, 0);
    vecs[12] = mk(1, 1, 10, 'h010, 5, 1, 0, 1);
    vecs[13] = mk(1, 0, 0,  'h010, 5, 1, 0, 0);
    vecs[14] = mk(1, 1, 15, 'h010, 5, 1, 0, 1);
    vecs[15] = mk(1, 0, 0,  'h010, 5, 1, 0, 0);
    vecs[16] = mk(1, 0, 0,  'h040, 5, 1, 0, 0);
    vecs[17] = mk(1, 0, 0,  'h040, 5, 1, 0, 0);
    vecs[18] = mk(1, 0, 0,  'h040, 5, 0, 0, 0);
    vecs[19] = mk(1, 1, 7,  'h040, 7, 0, 0, 0);
    vecs[20] = mk(1, 0, 0,  'h040, 7, 1, 0, 0);
    vecs[21] = mk(1, 0, 0,  'h040, 7, 1, 0, 0);
    vecs[22] = mk(1, 1, 2,  'h040, 2, 1, 0, 0);
    vecs[23] = mk(1, 0, 0,  'h040, 2, 0, 0, 0);
    vecs[24] = mk(0, 1, 4,  'h000, 2, 0, 0, 0);
    vecs[25] = mk(0, 1, 12, 'h000, 2, 0, 0, 0);
    vecs[26] = mk(1, 0, 0,  'h000, 2, 0, 0, 0);

    // Reset held with live inputs: everything stays cleared.
    rst_n = 1'b0; ena = 1'b1; data_in = '1; sel_in = 4'd3; sel_load = 1'b1;
    scan_en = 1'b0; dwell = 16'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("rst%0d", i), 0, 0, 0, 0);
    end
    sel_load = 1'b0; sel_in = '0; data_in = '0;
    rst_n = 1'b1;
    tick();
    check_all("rst_rel", 0, 0, 0, 0);

    for (int i = 0; i < 27; i++) begin
      ena = vecs[i].ena; sel_load = vecs[i].load; sel_in = vecs[i].sel; data_in = vecs[i].din;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].exp_sel, vecs[i].exp_dout,
                vecs[i].exp_pulse, vecs[i].exp_err);
    end
    ena = 1'b1; sel_load = 1'b0; sel_in = '0;

    // Scan wrap from selection 0 with all channels high: no pulse at any switch.
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    scan_en = 1'b1; dwell = 16'd4; data_in = '1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 44; k++) begin
      tick();
      check($sformatf("scan%0d_sel", k),   32'(cur_sel),   32'(exp_scan(k)));
      check($sformatf("scan%0d_dout", k),  32'(data_out),  32'(k >= 5));
      check($sformatf("scan%0d_pulse", k), 32'(pulse_out), 32'(0));
    end

    // Load on an advance cycle wins and restarts the dwell.
    sel_load = 1'b1; sel_in = 4'd7;
    tick();
    sel_load = 1'b0;
    check("prio_sel", 32'(cur_sel), 32'd7);
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("prio_hold%0d", j), 32'(cur_sel), 32'd7);
      check($sformatf("prio_pulse%0d", j), 32'(pulse_out), 32'd0);
    end
    tick();
    check("prio_adv", 32'(cur_sel), 32'd8);

    // Rejected load on an advance cycle does not block the advance.
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("inv_hold%0d", j), 32'(cur_sel), 32'd8);
    end
    sel_load = 1'b1; sel_in = 4'd12;
    tick();
    sel_load = 1'b0;
    check("inv_adv_sel", 32'(cur_sel), 32'd9);
    check("inv_adv_err", 32'(sel_err), 32'd1);

    // Enable freeze mid-dwell with a channel edge arriving while frozen.
    data_in = '0; dwell = 16'd8;
    tick();
    check("frz_err_clr", 32'(sel_err), 32'd0);
    tick();
    tick();
    check("frz_pre_dout", 32'(data_out), 32'd0);
    ena = 1'b0; data_in = '1;
    for (int j = 0; j < 6; j++) begin
      tick();
      check_all($sformatf("frz%0d", j), 9, 0, 0, 0);
    end
    ena = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      check($sformatf("frz_resume%0d", j), 32'(cur_sel), 32'd9);
    end
    tick();
    check("frz_wrap", 32'(cur_sel), 32'd1);

    // Reset mid-scan with scan_en still high: back to 0, scan re-entered on release.
    rst_n = 1'b0;
    #1;
    check_all("mrst", 0, 0, 0, 0);
    dwell = 16'd4;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("mrst_scan%0d", k), 32'(cur_sel), 32'(exp_scan(k)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
